// File: rtl/count_ctrl_pkg.sv
// Shared types and constants for the count_ctrl run controller.
package count_ctrl_pkg;

  localparam int unsigned COUNT_WIDTH_DEF = 4;
  localparam int unsigned PRESCALE_CNT_W  = 8;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/count_ctrl_prescaler.sv
// Increment prescaler for count_ctrl; only built when COUNT_CTRL_PRESCALE_EN is defined.
// tick is combinational so the counter advances on the same edge the phase wraps.
`ifdef COUNT_CTRL_PRESCALE_EN
module count_ctrl_prescaler
  import count_ctrl_pkg::*;
#(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = PRESCALE_CNT_W;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = en && (cnt_q == CW'(PRESCALE - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/count_ctrl.sv
// Run controller for a WIDTH-bit up-counter: one-shot / auto-reload runs against a latched limit.
// Define COUNT_CTRL_PRESCALE_EN to advance the counter only every PRESCALE RUN cycles.
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH    = COUNT_WIDTH_DEF,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  input  logic             done_ack,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             mode_q,  mode_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic             wrap_q,  wrap_d;
  logic             advance_c;
  logic             inc_c;

  if ((PRESCALE < 2) || (PRESCALE > 255)) begin : g_prescale_range
    $error("count_ctrl: PRESCALE must be within 2..255");
  end

`ifdef COUNT_CTRL_PRESCALE_EN
  logic ps_clr_c;
  logic ps_en_c;

  // Phase restarts on a fresh run; it only moves on edges that act as RUN edges.
  assign ps_clr_c = clear || ((state_q == IDLE) && start);
  assign ps_en_c  = !clear && (((state_q == RUN) && !stop) || ((state_q == PAUSE) && start));

  count_ctrl_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (ps_clr_c),
    .en    (ps_en_c),
    .tick  (inc_c)
  );
`else
  assign inc_c = 1'b1;
`endif

  // Next-state, counter and output decode.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    limit_d   = limit_q;
    mode_d    = mode_q;
    wrap_d    = 1'b0;
    advance_c = 1'b0;

    if (clear) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RUN;
            count_d = '0;
            limit_d = limit;
            mode_d  = mode;
          end
        end
        RUN: begin
          if (stop) begin
            state_d = PAUSE;
          end else begin
            advance_c = 1'b1;
          end
        end
        PAUSE: begin
          // The resume edge already counts as a RUN edge.
          if (start) begin
            state_d   = RUN;
            advance_c = 1'b1;
          end
        end
        DONE: begin
          if (done_ack) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      // Terminal compare precedes increment, so the counter never overflows.
      if (advance_c && inc_c) begin
        if (count_q == limit_q) begin
          if (mode_q == MODE_RELOAD) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end else begin
            state_d = DONE;
          end
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end
    end

    busy_d = (state_d == RUN) || (state_d == PAUSE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      limit_q <= '0;
      mode_q  <= MODE_ONESHOT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign wrap  = wrap_q;

endmodule
